// File: rtl/ha_mul_share_sched.sv
// ha_mul_share_sched
//   Time-shares one external combinational 8x8 approximate multiplier among
//   NREQ requesters. A round-robin arbiter picks one request, the operands are
//   held on mul_x/mul_y, the four half-adder-array rows are captured one cycle
//   later, reduced over a registered stage and returned with the requester ID.
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     req_valid/req_ready per-requester handshake (ready is one-hot or zero)
//     req_x, req_y        packed operands, requester i at [8i+7:8i]
//     mul_x, mul_y        operands to the multiplier (held until next accept)
//     ha_array_k_t/_b     row vectors returned by the multiplier
//     rsp_valid/rsp_ready response handshake
//     rsp_id, rsp_product served requester and saturated 16-bit product
//
//   Optional: define HA_MUL_SCHED_PERF_EN to add the saturating counters
//     perf_ops (response handshakes) and perf_busy (non-IDLE cycles).
module ha_mul_share_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_x,
  input  logic [8*NREQ-1:0] req_y,
  output logic [7:0]        mul_x,
  output logic [7:0]        mul_y,
  input  logic [8:0]        ha_array_0_t,
  input  logic [8:0]        ha_array_1_t,
  input  logic [8:0]        ha_array_2_t,
  input  logic [8:0]        ha_array_3_t,
  input  logic [6:0]        ha_array_0_b,
  input  logic [6:0]        ha_array_1_b,
  input  logic [6:0]        ha_array_2_b,
  input  logic [6:0]        ha_array_3_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_product
`ifdef HA_MUL_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_ops,
  output logic [31:0]       perf_busy
`endif
);

  typedef enum logic [1:0] {IDLE, MUL, RED, RSP} state_t;

  state_t             state;
  logic [IDW-1:0]     rr_ptr, id_q, grant;
  logic               any_req;
  int                 idx;

  logic [3:0][8:0]    t_in, t_q;
  logic [3:0][6:0]    b_in, b_q;
  logic [3:0][10:0]   row_val;
  logic [12:0]        p01_c, p23_c, p01_q, p23_q;
  logic [17:0]        sum;

  assign t_in = {ha_array_3_t, ha_array_2_t, ha_array_1_t, ha_array_0_t};
  assign b_in = {ha_array_3_b, ha_array_2_b, ha_array_1_b, ha_array_0_b};

  // Round-robin search from rr_ptr upward. Scanning offsets high to low lets
  // the smallest offset with a valid request be the last (winning) write.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        grant   = IDW'(idx);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = (state == IDLE) && any_req && (int'(grant) == i);
  end

  // Row k value: t bits at weight 2^j, b bits at weight 2^(j+2).
  for (genvar k = 0; k < 4; k++) begin : g_row
    assign row_val[k] = {2'b00, t_q[k]} + {2'b00, b_q[k], 2'b00};
  end

  assign p01_c = {2'b00, row_val[0]} + {row_val[1], 2'b00};
  assign p23_c = {2'b00, row_val[2]} + {row_val[3], 2'b00};

  // Final adder works off the partial registers, which stay frozen through
  // RSP, so the product is stable for the whole response window.
  assign sum         = {5'b0, p01_q} + {1'b0, p23_q, 4'b0000};
  assign rsp_product = (sum[17:16] != 2'b00) ? 16'hFFFF : sum[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      mul_x     <= '0;
      mul_y     <= '0;
      t_q       <= '0;
      b_q       <= '0;
      p01_q     <= '0;
      p23_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          mul_x  <= req_x[8*int'(grant) +: 8];
          mul_y  <= req_y[8*int'(grant) +: 8];
          id_q   <= grant;
          rr_ptr <= IDW'((int'(grant) + 1) % NREQ);
          state  <= MUL;
        end
        MUL: begin
          t_q   <= t_in;
          b_q   <= b_in;
          state <= RED;
        end
        RED: begin
          p01_q     <= p01_c;
          p23_q     <= p23_c;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HA_MUL_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops  <= '0;
      perf_busy <= '0;
    end else begin
      if (rsp_valid && rsp_ready && perf_ops != 32'hFFFF_FFFF)
        perf_ops <= perf_ops + 32'd1;
      if (state != IDLE && perf_busy != 32'hFFFF_FFFF)
        perf_busy <= perf_busy + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ha_mul_share_sched.md
Name: ha_mul_share_sched

Overview:
- Time-shares one combinational 8x8 approximate multiplier with 4-row half-adder-array outputs among NREQ requesters.
- Arbitrates requests round-robin, drives the operands, and captures the four ha_array rows.
- Reduces the rows to a 16-bit product over registered stages and returns it with the requester ID.
- Sits between requester pipelines and the multiplier instance; the multiplier itself is external.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester ID width; must satisfy 2^IDW >= NREQ

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept (one-hot or zero)
req_x  input  8*NREQ  operand x, requester i at bits [8i+7:8i]
req_y  input  8*NREQ  operand y, same packing
mul_x  output  8  operand to multiplier
mul_y  output  8  operand to multiplier
ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t  input  9 each  row "t" vectors from multiplier
ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b  input  7 each  row "b" vectors from multiplier
rsp_valid  output  1  response valid
rsp_ready  input  1  response accept
rsp_id  output  IDW  index of the served requester
rsp_product  output  16  reduced product

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low. All state registers clear on assertion regardless of the clock.
- Reset values: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_product=0, mul_x=0, mul_y=0, all row and partial registers 0.
- FSM states: IDLE, MUL, RED, RSP.
- IDLE:
  - The grant is the first i with req_valid[i]=1, searching from rr_ptr upward with wrap.
  - req_ready[grant]=1 combinationally; all other req_ready bits are 0.
  - If no req_valid bit is set, stay in IDLE.
  - On the accepting edge:
    - latch op_x/op_y and id into registers;
    - set rr_ptr=(grant+1) mod NREQ;
    - go to MUL.
- req_ready is 0 in every state other than IDLE. Only one operation is outstanding at a time.
- mul_x and mul_y are driven from the op registers. They hold their value until the next accept.
- MUL: lasts one cycle, so the multiplier settles within one clock. At the end of MUL, register all 8 row vectors and go to RED.
- Row value:
  - R_k = t_k + (b_k << 2), 11-bit zero-extended.
  - t bit j has weight 2^j; b bit j has weight 2^(j+2).
- RED: lasts one cycle.
  - Register p01 = R_0 + (R_1 << 2) and p23 = R_2 + (R_3 << 2), 13 bits each.
- After the RED cycle:
  - sum = p01 + (p23 << 4), computed at 18 bits;
  - rsp_product = sum > 16'hFFFF ? 16'hFFFF : sum[15:0] (saturating);
  - rsp_id = latched id; rsp_valid=1; go to RSP.
- RSP:
  - Hold rsp_valid, rsp_id and rsp_product stable while rsp_ready=0.
  - On an edge with rsp_valid and rsp_ready both 1: rsp_valid=0, go to IDLE.
  - The next request is accepted no earlier than the cycle after that edge.
- Latency: rsp_valid rises 3 clock edges after the accepting edge. Minimum issue interval is 4 cycles.
- Fairness: a requester that holds req_valid continuously is granted within NREQ operations.
- A requester that drops req_valid while not granted loses nothing; no request state is stored for it.
- Reset mid-operation: the in-flight operation is discarded and no response is issued. rr_ptr returns to 0.
- Requester indices >= NREQ never exist. rsp_id upper bits are zero when NREQ < 2^IDW.

Optional Feature:
- Macro: HA_MUL_SCHED_PERF_EN.
- When defined, add two outputs:
  - perf_ops (32): increments on each response handshake;
  - perf_busy (32): increments on every cycle the state is not IDLE.
- Both counters saturate at 32'hFFFFFFFF and reset to 0 on rst_n.
- When not defined, neither the ports nor the counter logic exist. Function is otherwise identical.

Test Plan:
- Single request: req_valid=4'b0001, x=8'h03, y=8'h05; stub drives row0 t=9'h00F, all other rows 0 -> req_ready[0] for one cycle; rsp_valid 3 edges later; rsp_id=0; rsp_product=16'h000F.
- Row weighting: stub drives only ha_array_3_b=7'h01 -> rsp_product=16'h0100 (1<<2<<6). Then only ha_array_2_t=9'h003 -> 16'h0030.
- Saturation: all t=9'h1FF and all b=7'h7F -> internal sum 86615 -> rsp_product=16'hFFFF.
- Round-robin: req_valid=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0. Then req_valid=4'b1010 after a grant of 1 -> next grant 3, then 1.
- Backpressure: rsp_ready=0 for 5 cycles during RSP -> rsp_valid, rsp_id and rsp_product stable; req_ready stays 0. rsp_ready=1 -> IDLE the next cycle.
- Reset mid-op: assert rst_n=0 asynchronously during RED -> all outputs go to 0 immediately, no response is issued, and the first grant after release is requester 0. With HA_MUL_SCHED_PERF_EN defined, perf_ops counts only completed responses.
